// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEFAULT_BITSIZE = 64;
  localparam int unsigned DEFAULT_REGSIZE = 32;
  localparam int unsigned XZR             = 31;

  // True when a register index names real, writable storage (in range and not XZR).
  function automatic logic selActive(input int unsigned sel,
                                     input int unsigned regSize,
                                     input int unsigned zeroReg);
    return (sel < regSize) && (sel != zeroReg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, reserve wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REGSIZE  = DEFAULT_REGSIZE,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = XZR,
  parameter int unsigned AW       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reserveEnable,
  input  logic [AW-1:0]         reserveSelect,
  input  logic [REGSIZE-1:0]    writeHit,
  input  logic [NUM_RD*AW-1:0]  readSelect,
  input  logic [NUM_RD-1:0]     readBypass,
  output logic [NUM_RD-1:0]     readBusy,
  output logic [REGSIZE-1:0]    busyVector
);

  logic [REGSIZE-1:0] busyNext;
  logic [AW-1:0]      rdSel;

  // Clear on writeback first, then set on reserve so a same-cycle reserve dominates.
  always_comb begin
    busyNext = busyVector & ~writeHit;
    if (reserveEnable && selActive(32'(reserveSelect), REGSIZE, ZERO_REG)) begin
      busyNext[reserveSelect] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busyVector <= '0;
    end else begin
      busyVector <= busyNext;
    end
  end

  // A register being written this cycle is not busy from the reader's point of view.
  always_comb begin
    readBusy = '0;
    rdSel    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdSel = readSelect[i*AW +: AW];
      if (selActive(32'(rdSel), REGSIZE, ZERO_REG)) begin
        readBusy[i] = busyVector[rdSel] & ~readBypass[i];
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: async reads, prioritised sync writes, XZR, optional
// write-to-read bypass and a busy scoreboard for in-flight producers.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned BITSIZE  = DEFAULT_BITSIZE,
  parameter int unsigned REGSIZE  = DEFAULT_REGSIZE,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = XZR,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = (REGSIZE > 1) ? $clog2(REGSIZE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_RD*AW-1:0]      ReadSelect,
  output logic [NUM_RD*BITSIZE-1:0] ReadData,
  output logic [NUM_RD-1:0]         ReadBusy,
  input  logic [NUM_WR-1:0]         WriteEnable,
  input  logic [NUM_WR*AW-1:0]      WriteSelect,
  input  logic [NUM_WR*BITSIZE-1:0] WriteData,
  input  logic                      ReserveEnable,
  input  logic [AW-1:0]             ReserveSelect,
  output logic [REGSIZE-1:0]        BusyVector
);

  logic [BITSIZE-1:0] regs  [REGSIZE];
  logic [BITSIZE-1:0] wrVal [REGSIZE];
  logic [REGSIZE-1:0] wrHit;
  logic [NUM_RD-1:0]  readBypass;
  logic [AW-1:0]      rdSel;
  logic [BITSIZE-1:0] rdVal;
  logic               bypassOn;

  // Per-register write resolution; later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    wrHit = '0;
    for (int r = 0; r < REGSIZE; r++) begin
      wrVal[r] = '0;
      if (selActive(32'(r), REGSIZE, ZERO_REG)) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (WriteEnable[w] && (WriteSelect[w*AW +: AW] == AW'(r))) begin
            wrHit[r] = 1'b1;
            wrVal[r] = WriteData[w*BITSIZE +: BITSIZE];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REGSIZE; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REGSIZE; r++) begin
        if (wrHit[r]) begin
          regs[r] <= wrVal[r];
        end
      end
    end
  end

  // Forwarding is suppressed during reset so every port reads zero while rst is low.
  assign bypassOn = (BYPASS != 0) && rst;

  always_comb begin
    ReadData   = '0;
    readBypass = '0;
    rdSel      = '0;
    rdVal      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdSel = ReadSelect[i*AW +: AW];
      rdVal = '0;
      if (selActive(32'(rdSel), REGSIZE, ZERO_REG)) begin
        rdVal = regs[rdSel];
        for (int w = 0; w < NUM_WR; w++) begin
          if (bypassOn && WriteEnable[w] && (WriteSelect[w*AW +: AW] == rdSel)) begin
            rdVal         = WriteData[w*BITSIZE +: BITSIZE];
            readBypass[i] = 1'b1;
          end
        end
      end
      ReadData[i*BITSIZE +: BITSIZE] = rdVal;
    end
  end

  regfile_scoreboard #(
    .REGSIZE  (REGSIZE),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) uScoreboard (
    .clk           (clk),
    .rst           (rst),
    .reserveEnable (ReserveEnable),
    .reserveSelect (ReserveSelect),
    .writeHit      (wrHit),
    .readSelect    (ReadSelect),
    .readBypass    (readBypass),
    .readBusy      (ReadBusy),
    .busyVector    (BusyVector)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with default parameters (64-bit, 32 regs, 2R/2W, bypass on).
module tb_register_file_mp;

  logic          clk;
  logic          rst;
  logic [9:0]    readSelect;
  logic [127:0]  readData;
  logic [1:0]    readBusy;
  logic [1:0]    writeEnable;
  logic [9:0]    writeSelect;
  logic [127:0]  writeData;
  logic          reserveEnable;
  logic [4:0]    reserveSelect;
  logic [31:0]   busyVector;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [4:0]  sel0;
    logic [4:0]  sel1;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } rdVec_t;

  rdVec_t vecs [32];

  register_file_mp dut (
    .clk           (clk),
    .rst           (rst),
    .ReadSelect    (readSelect),
    .ReadData      (readData),
    .ReadBusy      (readBusy),
    .WriteEnable   (writeEnable),
    .WriteSelect   (writeSelect),
    .WriteData     (writeData),
    .ReserveEnable (reserveEnable),
    .ReserveSelect (reserveSelect),
    .BusyVector    (busyVector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expVal(input int r);
    return (r == 31) ? 64'd0 : 64'(100 + 10 * r);
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin
      vecs[r].sel0 = 5'(r);
      vecs[r].sel1 = 5'(31 - r);
      vecs[r].exp0 = expVal(r);
      vecs[r].exp1 = expVal(31 - r);
    end

    rst           = 1'b0;
    readSelect    = {5'd9, 5'd5};
    writeEnable   = 2'b00;
    writeSelect   = '0;
    writeData     = '0;
    reserveEnable = 1'b0;
    reserveSelect = '0;

    // Reset: everything reads zero
    #1;
    check("rst_data0", readData[63:0], 64'd0);
    check("rst_busyvec", 64'(busyVector), 64'd0);
    #3 rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      readSelect = {5'(31 - r), 5'(r)};
      #1;
      check("sweep_data0", readData[63:0], 64'd0);
      check("sweep_data1", readData[127:64], 64'd0);
    end
    check("sweep_busyvec", 64'(busyVector), 64'd0);
    tick();

    // Fill r0..r31 through port 0; r31 is XZR and must stay zero
    for (int r = 0; r < 32; r++) begin
      writeEnable = 2'b01;
      writeSelect = {5'd0, 5'(r)};
      writeData   = {64'd0, 64'(100 + 10 * r)};
      tick();
    end
    writeEnable = 2'b00;

    for (int v = 0; v < 32; v++) begin
      readSelect = {vecs[v].sel1, vecs[v].sel0};
      #1;
      check("table_data0", readData[63:0], vecs[v].exp0);
      check("table_data1", readData[127:64], vecs[v].exp1);
      check("table_busy", 64'(readBusy), 64'd0);
    end
    tick();

    // Collision on r5: port 1 wins, also on the bypass path
    writeEnable = 2'b11;
    writeSelect = {5'd5, 5'd5};
    writeData   = {64'h5555, 64'hAAAA};
    readSelect  = {5'd5, 5'd5};
    #1;
    check("coll_bypass0", readData[63:0], 64'h5555);
    check("coll_bypass1", readData[127:64], 64'h5555);
    tick();
    writeEnable = 2'b00;
    #1;
    check("coll_stored", readData[63:0], 64'h5555);
    tick();

    // Reserve r7, write it three cycles later
    reserveEnable = 1'b1;
    reserveSelect = 5'd7;
    readSelect    = {5'd6, 5'd7};
    #1;
    check("sb_pre_busy", 64'(readBusy), 64'd0);
    tick();
    reserveEnable = 1'b0;
    check("sb_vec_set", 64'(busyVector), 64'h80);
    check("sb_rdbusy", 64'(readBusy), 64'b01);
    check("sb_old_data", readData[63:0], 64'd170);
    tick();
    tick();
    check("sb_still_busy", 64'(readBusy), 64'b01);
    writeEnable = 2'b01;
    writeSelect = {5'd0, 5'd7};
    writeData   = {64'd0, 64'd42};
    #1;
    check("sb_wr_busy", 64'(readBusy), 64'd0);
    check("sb_wr_bypass", readData[63:0], 64'd42);
    tick();
    writeEnable = 2'b00;
    check("sb_vec_clear", 64'(busyVector), 64'd0);
    check("sb_wr_data", readData[63:0], 64'd42);

    // Reserve and write r9 together: reserve wins; XZR never becomes busy
    reserveEnable = 1'b1;
    reserveSelect = 5'd9;
    writeEnable   = 2'b01;
    writeSelect   = {5'd0, 5'd9};
    writeData     = {64'd0, 64'd7};
    readSelect    = {5'd31, 5'd9};
    tick();
    writeEnable   = 2'b00;
    reserveSelect = 5'd31;
    #1;
    check("sim_data", readData[63:0], 64'd7);
    check("sim_vec", 64'(busyVector), 64'h200);
    check("sim_rdbusy", 64'(readBusy), 64'b01);
    tick();
    reserveEnable = 1'b0;
    check("xzr_vec", 64'(busyVector), 64'h200);
    check("xzr_rdbusy", 64'(readBusy), 64'b01);

    // Reset mid-operation with a write held across it
    reserveEnable = 1'b1;
    reserveSelect = 5'd3;
    writeEnable   = 2'b01;
    writeSelect   = {5'd0, 5'd3};
    writeData     = {64'd0, 64'd55};
    readSelect    = {5'd9, 5'd3};
    tick();
    reserveEnable = 1'b0;
    writeEnable   = 2'b00;
    #1;
    check("mid_data", readData[63:0], 64'd55);
    check("mid_vec", 64'(busyVector), 64'h208);
    writeEnable = 2'b01;
    writeData   = {64'd0, 64'd99};
    #1;
    check("mid_bypass", readData[63:0], 64'd99);
    #2 rst = 1'b0;
    #1;
    check("arst_data", readData[63:0], 64'd0);
    check("arst_vec", 64'(busyVector), 64'd0);
    check("arst_rdbusy", 64'(readBusy), 64'd0);
    tick();
    check("arst_edge_data", readData[63:0], 64'd0);
    writeEnable = 2'b00;
    #2 rst = 1'b1;
    tick();
    check("post_r3", readData[63:0], 64'd0);
    check("post_r9", readData[127:64], 64'd0);
    check("post_vec", 64'(busyVector), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
